// File: rtl/jtframe_db9_pkg.sv
// jtframe_db9_pkg: shared types for the DB9 joystick scanner
// scan phases, jtframe button bit positions and pad type codes
package jtframe_db9_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PH0    = 4'd1,
        ST_PH1    = 4'd2,
        ST_PH2    = 4'd3,
        ST_PH3    = 4'd4,
        ST_PH4    = 4'd5,
        ST_PH5    = 4'd6,
        ST_PH6    = 4'd7,
        ST_PH7    = 4'd8,
        ST_COMMIT = 4'd9
    } phase_t;

    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_A     = 4;
    localparam int B_B     = 5;
    localparam int B_C     = 6;
    localparam int B_X     = 7;
    localparam int B_Y     = 8;
    localparam int B_Z     = 9;
    localparam int B_START = 10;
    localparam int B_MODE  = 11;

    localparam logic [1:0] PT_ATARI = 2'd0;
    localparam logic [1:0] PT_MD3   = 2'd1;
    localparam logic [1:0] PT_MD6   = 2'd2;

    function automatic phase_t next_phase(input phase_t p);
        return (p == ST_COMMIT) ? ST_IDLE : phase_t'(p + 4'd1);
    endfunction

    // PHk encodes as k+1, so bit 0 is high for even k
    // COMMIT keeps the PH7 level so the high time is IDLE+PH0 only
    function automatic logic sel_level(input phase_t p);
        logic [3:0] v;
        v = p;
        if (p == ST_IDLE)
            return 1'b1;
        else if (p == ST_COMMIT)
            return 1'b0;
        else
            return v[0];
    endfunction

endpackage

// File: rtl/jtframe_db9_deb.sv
// jtframe_db9_deb: per-port scan debouncer
// commits a word/type only after DEB_SCANS identical scans
module jtframe_db9_deb
    import jtframe_db9_pkg::*;
#(
    parameter int DEB_SCANS  = 2,
    parameter int ACTIVE_LOW = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [11:0] word_in,
    input  logic [1:0]  type_in,
    output logic [11:0] word_out,
    output logic [1:0]  type_out
);

    localparam logic [2:0] NEED = 3'(DEB_SCANS);

    logic [13:0] cand;
    logic [13:0] stable;
    logic [13:0] in_w;
    logic [2:0]  hits;
    logic [2:0]  hits_nxt;

    assign in_w = {type_in, word_in};

    assign hits_nxt = (in_w != cand)   ? 3'd1 :
                      (hits == 3'd7)   ? 3'd7 :
                      hits + 3'd1;

    // track repeat count of the latest scan and promote it when stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= '0;
            hits   <= '0;
            stable <= '0;
        end else if (commit) begin
            cand <= in_w;
            hits <= hits_nxt;
            if (hits_nxt >= NEED)
                stable <= in_w;
        end
    end

    assign word_out = (ACTIVE_LOW != 0) ? ~stable[11:0] : stable[11:0];
    assign type_out = stable[13:12];

endmodule

// File: rtl/jtframe_db9_scan.sv
// jtframe_db9_scan: multi-port DB9 scanner with Mega Drive 3/6 support
// drives the shared select line, decodes and debounces each pad
module jtframe_db9_scan
    import jtframe_db9_pkg::*;
#(
    parameter int NPORTS     = 2,
    parameter int PHASE_CNT  = 480,
    parameter int IDLE_CNT   = 96000,
    parameter int DEB_SCANS  = 2,
    parameter int ACTIVE_LOW = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS*6-1:0]  joy_in,
    output logic                 joy_sel,
    output logic [NPORTS*12-1:0] joy_out,
    output logic [NPORTS*2-1:0]  pad_type,
    output logic                 scan_done
);

    localparam int CNT_MAX = (IDLE_CNT > PHASE_CNT) ? IDLE_CNT : PHASE_CNT;
    localparam int CW      = $clog2(CNT_MAX);

    logic [1:0]          rst_sr;
    logic                rst_i;
    logic [NPORTS*6-1:0] s1;
    logic [NPORTS*6-1:0] s2;
    phase_t              st;
    logic [CW-1:0]       cnt;
    logic                last;

    // async assert, clocked release of the internal reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rst_sr <= 2'b11;
        else
            rst_sr <= {rst_sr[0], 1'b0};
    end

    assign rst_i = rst_sr[1];

    // two-flop synchroniser for the raw pad pins
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= joy_in;
            s2 <= s1;
        end
    end

    assign last = (st == ST_IDLE) ? (cnt == CW'(IDLE_CNT - 1)) :
                                    (cnt == CW'(PHASE_CNT - 1));

    // scan sequencer: idle, eight select phases, one commit cycle
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            joy_sel   <= 1'b1;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (st == ST_COMMIT) begin
                st      <= ST_IDLE;
                cnt     <= '0;
                joy_sel <= sel_level(ST_IDLE);
            end else if (last) begin
                st        <= next_phase(st);
                cnt       <= '0;
                joy_sel   <= sel_level(next_phase(st));
                scan_done <= (st == ST_PH7);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [5:0]  pin;
        logic [11:0] ph0_w;
        logic [11:0] wd;
        logic [11:0] word;
        logic [1:0]  kind;
        logic        md;
        logic        six;
        logic        lr0;

        assign pin = ~s2[6*p +: 6];

        // directions and B/C as seen with select high
        always_comb begin
            ph0_w          = '0;
            ph0_w[B_UP]    = pin[0];
            ph0_w[B_DOWN]  = pin[1];
            ph0_w[B_LEFT]  = pin[2];
            ph0_w[B_RIGHT] = pin[3];
            ph0_w[B_B]     = pin[4];
            ph0_w[B_C]     = pin[5];
        end

        // capture each phase on its last cycle
        // a real pad cannot show left+right with select high,
        // so that excludes an all-directions Atari stick from MD-6
        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) begin
                wd  <= '0;
                md  <= 1'b0;
                six <= 1'b0;
                lr0 <= 1'b0;
            end else if (last) begin
                case (st)
                    ST_PH0: begin
                        wd  <= ph0_w;
                        lr0 <= pin[2] & pin[3];
                        md  <= 1'b0;
                        six <= 1'b0;
                    end
                    ST_PH1: begin
                        wd[B_A]     <= pin[4];
                        wd[B_START] <= pin[5];
                        md          <= pin[2] & pin[3];
                    end
                    ST_PH5: begin
                        six <= md & (&pin[3:0]) & ~lr0;
                    end
                    ST_PH6: begin
                        if (six) begin
                            wd[B_Z]    <= pin[0];
                            wd[B_Y]    <= pin[1];
                            wd[B_X]    <= pin[2];
                            wd[B_MODE] <= pin[3];
                        end
                    end
                    default: ;
                endcase
            end
        end

        // classify the scan and mask buttons the pad cannot report
        always_comb begin
            word = wd;
            kind = PT_ATARI;
            if (!md) begin
                word[B_A]     = 1'b0;
                word[B_START] = 1'b0;
                word[B_X]     = 1'b0;
                word[B_Y]     = 1'b0;
                word[B_Z]     = 1'b0;
                word[B_MODE]  = 1'b0;
            end else if (!six) begin
                kind         = PT_MD3;
                word[B_X]    = 1'b0;
                word[B_Y]    = 1'b0;
                word[B_Z]    = 1'b0;
                word[B_MODE] = 1'b0;
            end else begin
                kind = PT_MD6;
            end
        end

        jtframe_db9_deb #(
            .DEB_SCANS  (DEB_SCANS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_deb (
            .clk      (clk),
            .rst      (rst_i),
            .commit   (scan_done),
            .word_in  (word),
            .type_in  (kind),
            .word_out (joy_out[12*p +: 12]),
            .type_out (pad_type[2*p +: 2])
        );
    end

endmodule
